lenet_input_streamer: RTL and testbench
=======================================

// Module: lenet_input_streamer
// PURPOSE
//  Downstream neighbour of the camera core. It drains the 32x32 LeNet input buffer (1024x8 BRAM)
//  that the core fills through addr_mem2/lenet_we, and streams it to the CNN as a valid/ready
//  raster stream. Padding pixels come from PAD_VALUE, not from memory. The block drives the core's
//  lenet_doing_signal low while streaming, so the buffer is not overwritten mid-read.
// PARAMETERS
//  CNN_INPUT_WIDTH   28     interior columns
//  CNN_INPUT_HEIGHT  28     interior rows
//  CNN_INPUT_PAD     2      pad ring width; REAL_W = REAL_H = 2*PAD+28 = 32
//  PAD_VALUE         8'h00  value emitted at every pad position
//  INVERT            0      1: interior data emitted as 8'hFF - rd_data (pad unaffected)
// PORTS
//  clk24               in   1   system clock, shared with the camera core
//  rst                 in   1   synchronous reset, active-high
//  lenet_data_ready    in   1   1-cycle pulse from the core: buffer complete
//  rd_en               out  1   BRAM read enable
//  rd_addr             out  10  BRAM read address = row*REAL_W + col
//  rd_data             in   8   BRAM read data, valid exactly 1 cycle after rd_en
//  px_data             out  8   stream pixel
//  px_valid            out  1   stream valid
//  px_ready            in   1   stream ready from the CNN
//  px_last             out  1   high on the final beat (index 1023)
//  lenet_doing_signal  out  1   to core: 1 = buffer free to be rewritten
//  busy                out  1   high when state != IDLE
//  drop_cnt            out  8   count of pulses ignored while busy, saturating
// BEHAVIOUR
//  Reset values: px_valid=0, px_data=0, px_last=0, rd_en=0, rd_addr=0, busy=0, drop_cnt=0,
//   lenet_doing_signal=1, state=IDLE; FIFO, in-flight flag and position counters cleared.
//  Reset mid-stream aborts immediately. Partial output is discarded, with no px_last.
//  FSM:
//   IDLE   -> STREAM on a lenet_data_ready pulse (cycle N); lenet_doing_signal=0 from N+1.
//   STREAM: fetch position counter (row, col) runs 0..31 x 0..31 in row-major order.
//   STREAM -> DRAIN after the fetch for index 1023 is issued.
//   DRAIN  -> IDLE on the cycle the px_last beat handshakes (px_valid & px_ready & px_last).
//          lenet_doing_signal returns to 1 and busy to 0 on the following cycle.
//  Fetch: one position per cycle. Position is pad if row<PAD, row>=PAD+28, col<PAD or col>=PAD+28.
//   Interior fetch: rd_en=1 with rd_addr=row*32+col.
//   Pad fetch: rd_en=0; PAD_VALUE enters the pipeline with the same 1-cycle latency.
//  Output: 2-entry FIFO in front of px_*.
//   A fetch issues only if occ - pop + inflight < 2, where pop = px_valid & px_ready this cycle.
//   This sustains 1 beat/cycle while px_ready=1 and can never overflow.
//  Latency: pulse at N -> first fetch at N+1 -> px_valid=1 at N+2 (px_ready held 1).
//   1024 contiguous beats follow; the last beat is at N+1025.
//  Stream rules:
//   While px_valid & !px_ready, px_data and px_last hold stable.
//   px_valid never deasserts without a handshake.
//  px_last=1 only on beat 1023. Pad beats total 240; interior beats 784 (one rd_en each).
//  A lenet_data_ready pulse outside IDLE (including the exit cycle) is ignored;
//   drop_cnt increments and saturates at 255.
//  Simultaneous pulse and rst: rst wins.
// TESTING
//  1. BRAM[i]=i[7:0], px_ready=1, pulse at N ->
//     px_valid first at N+2; 1024 back-to-back beats; interior beat k = k[7:0]; pad beats = 8'h00;
//     first rd_addr = 66; rd_en asserted 784 times; px_last on beat 1023 only.
//  2. Random px_ready (50%) with the test-1 data ->
//     identical 1024-beat sequence; no loss or duplication; data stable during stalls; FIFO occ <= 2.
//  3. Second pulse at beat 300 ->
//     ignored; drop_cnt = 1; stream completes normally; lenet_doing_signal = 1 after px_last.
//  4. 300 ignored pulses -> drop_cnt saturates at 255.
//  5. rst at beat 500 ->
//     next cycle px_valid=0, lenet_doing_signal=1, busy=0; a new pulse restarts at beat 0, rd_addr 66.
//  6. INVERT=1, PAD_VALUE=8'h7F, BRAM all 8'h10 -> interior beats 8'hEF; pad beats 8'h7F.

Source files
------------

// File: rtl/lenet_input_streamer.sv
// lenet_input_streamer: drains the 32x32 LeNet input buffer and streams it
// to the CNN as a row-major valid/ready raster, synthesising the pad ring.
// The beat whose BRAM read returns this cycle is exposed directly on px_*
// (bypass), so the first pixel appears two cycles after the start pulse.
// A 2-entry FIFO absorbs back-pressure from px_ready.
module lenet_input_streamer #(
  parameter int         CNN_INPUT_WIDTH  = 28,
  parameter int         CNN_INPUT_HEIGHT = 28,
  parameter int         CNN_INPUT_PAD    = 2,
  parameter logic [7:0] PAD_VALUE        = 8'h00,
  parameter bit         INVERT           = 1'b0
) (
  input  logic       clk24,
  input  logic       rst,
  input  logic       lenet_data_ready,
  output logic       rd_en,
  output logic [9:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [7:0] px_data,
  output logic       px_valid,
  input  logic       px_ready,
  output logic       px_last,
  output logic       lenet_doing_signal,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int REAL_W = 2*CNN_INPUT_PAD + CNN_INPUT_WIDTH;
  localparam int REAL_H = 2*CNN_INPUT_PAD + CNN_INPUT_HEIGHT;

  localparam logic [5:0] COL_LO  = 6'(CNN_INPUT_PAD);
  localparam logic [5:0] COL_HI  = 6'(CNN_INPUT_PAD + CNN_INPUT_WIDTH);
  localparam logic [5:0] ROW_LO  = 6'(CNN_INPUT_PAD);
  localparam logic [5:0] ROW_HI  = 6'(CNN_INPUT_PAD + CNN_INPUT_HEIGHT);
  localparam logic [5:0] COL_MAX = 6'(REAL_W - 1);
  localparam logic [5:0] ROW_MAX = 6'(REAL_H - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0] state, state_nx;

  // fetch position
  logic [5:0] row, col;
  logic [9:0] addr;
  logic       pos_pad, pos_last;

  // beat whose data arrives this cycle (BRAM read or pad)
  logic       infl, infl_pad, infl_last;
  logic [7:0] infl_data;

  // 2-entry output FIFO
  logic [1:0][7:0] fifo_data;
  logic [1:0]      fifo_last;
  logic            wp, rp;
  logic [1:0]      occ;

  logic       pop, push, fifo_pop, fetch;
  logic [2:0] pending;

  // position classification and read port
  always_comb begin
    pos_pad  = (row < ROW_LO) || (row >= ROW_HI) || (col < COL_LO) || (col >= COL_HI);
    pos_last = (row == ROW_MAX) && (col == COL_MAX);
    rd_addr  = addr;
    rd_en    = fetch && !pos_pad;
  end

  // returning beat value; pad beats never look at rd_data
  always_comb begin
    infl_data = rd_data;
    if (infl_pad)    infl_data = PAD_VALUE;
    else if (INVERT) infl_data = 8'hFF - rd_data;
  end

  // stream outputs: FIFO head when occupied, otherwise the bypassed beat
  always_comb begin
    px_valid = (occ != 2'd0) || infl;
    px_data  = 8'h00;
    px_last  = 1'b0;
    if (occ != 2'd0) begin
      px_data = fifo_data[rp];
      px_last = fifo_last[rp];
    end else if (infl) begin
      px_data = infl_data;
      px_last = infl_last;
    end
  end

  // flow control: one fetch per cycle while the pending count after this
  // cycle's pop stays below the FIFO depth
  always_comb begin
    pop      = px_valid && px_ready;
    pending  = {1'b0, occ} + {2'b00, infl};
    fetch    = (state == S_STREAM) && !rst && ((pending - {2'b00, pop}) < 3'd2);
    push     = infl && !(pop && (occ == 2'd0));
    fifo_pop = pop && (occ != 2'd0);
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (lenet_data_ready) state_nx = S_STREAM;
      S_STREAM: if (fetch && pos_last) state_nx = S_DRAIN;
      S_DRAIN:  if (pop && px_last) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // control state, handshake to the core and drop counter
  always_ff @(posedge clk24) begin
    if (rst) begin
      state              <= S_IDLE;
      lenet_doing_signal <= 1'b1;
      drop_cnt           <= 8'd0;
    end else begin
      state              <= state_nx;
      lenet_doing_signal <= (state_nx == S_IDLE);
      if (lenet_data_ready && (state != S_IDLE) && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // fetch position counters, row-major; they wrap to 0 after the last pixel
  always_ff @(posedge clk24) begin
    if (rst) begin
      row  <= 6'd0;
      col  <= 6'd0;
      addr <= 10'd0;
    end else if (fetch) begin
      if (pos_last) begin
        row  <= 6'd0;
        col  <= 6'd0;
        addr <= 10'd0;
      end else begin
        addr <= addr + 10'd1;
        if (col == COL_MAX) begin
          col <= 6'd0;
          row <= row + 6'd1;
        end else begin
          col <= col + 6'd1;
        end
      end
    end
  end

  // in-flight beat tag, valid for the cycle the read data returns
  always_ff @(posedge clk24) begin
    if (rst) begin
      infl      <= 1'b0;
      infl_pad  <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      infl      <= fetch;
      infl_pad  <= fetch && pos_pad;
      infl_last <= fetch && pos_last;
    end
  end

  // output FIFO: captures the returning beat when it is not consumed directly
  always_ff @(posedge clk24) begin
    if (rst) begin
      fifo_data <= '0;
      fifo_last <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      occ       <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wp] <= infl_data;
        fifo_last[wp] <= infl_last;
        wp            <= ~wp;
      end
      if (fifo_pop) rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

endmodule

// File: tb/tb_lenet_input_streamer.sv
// Bench for lenet_input_streamer: scoreboard of expected beats filled by the
// stimulus thread, drained by a negedge monitor. A second instance covers
// INVERT=1 with a non-zero pad value.
module tb_lenet_input_streamer;

  logic       clk24 = 1'b0;
  logic       rst = 1'b1;
  logic       lenet_data_ready = 1'b0;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] px_data;
  logic       px_valid;
  logic       px_ready = 1'b0;
  logic       px_last;
  logic       lenet_doing_signal;
  logic       busy;
  logic [7:0] drop_cnt;

  logic       pulse2 = 1'b0;
  logic       rd_en2;
  logic [9:0] rd_addr2;
  logic [7:0] rd_data2 = 8'h00;
  logic [7:0] px_data2;
  logic       px_valid2;
  logic       px_ready2 = 1'b1;
  logic       px_last2;
  logic       doing2;
  logic       busy2;
  logic [7:0] drop2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: low, 1: high, 2: random

  logic [8:0] sb[$];
  logic [7:0] mem[1024];

  int  beat = 0;
  int  last_cyc = 0;
  int  rd_total = 0;
  int  first_addr = -1;
  bit  seen = 0;
  int  beat2 = 0;

  lenet_input_streamer dut (
    .clk24(clk24), .rst(rst), .lenet_data_ready(lenet_data_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready), .px_last(px_last),
    .lenet_doing_signal(lenet_doing_signal), .busy(busy), .drop_cnt(drop_cnt)
  );

  lenet_input_streamer #(.PAD_VALUE(8'h7F), .INVERT(1'b1)) dut2 (
    .clk24(clk24), .rst(rst), .lenet_data_ready(pulse2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .px_data(px_data2), .px_valid(px_valid2), .px_ready(px_ready2), .px_last(px_last2),
    .lenet_doing_signal(doing2), .busy(busy2), .drop_cnt(drop2)
  );

  always #5 clk24 = ~clk24;
  always @(posedge clk24) cyc <= cyc + 1;

  // BRAM models: 1-cycle read latency
  always @(posedge clk24) if (rd_en) rd_data <= mem[rd_addr];
  always @(posedge clk24) rd_data2 <= rd_en2 ? 8'h10 : 8'h55;

  always @(posedge clk24) begin
    #1;
    case (rdy_mode)
      0:       px_ready = 1'b0;
      1:       px_ready = 1'b1;
      default: px_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_pad(input int k);
    int r = k / 32;
    int c = k % 32;
    return (r < 2) || (r >= 30) || (c < 2) || (c >= 30);
  endfunction

  task automatic push_frame();
    logic [7:0] d;
    logic       l;
    for (int k = 0; k < 1024; k++) begin
      d = is_pad(k) ? 8'h00 : 8'(k);
      l = (k == 1023);
      sb.push_back({l, d});
    end
  endtask

  task automatic pulse1();
    @(posedge clk24); #1 lenet_data_ready = 1'b1;
    @(posedge clk24); #1 lenet_data_ready = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    @(negedge clk24);
    while ((sb.size() != 0 || busy) && n < 6000) begin
      @(negedge clk24);
      n++;
    end
    chk(nm, int'(n >= 6000), 0);
  endtask

  task automatic wait_beat(input int b);
    int n = 0;
    while (beat < b && n < 6000) begin
      @(negedge clk24);
      n++;
    end
    chk("wait_beat_timeout", int'(n >= 6000), 0);
  endtask

  // monitor for the main instance
  initial forever begin
    logic [8:0] e;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    @(negedge clk24);
    if (rst) begin
      prev_stall = 0;
      beat = 0;
    end else begin
      if (!busy) seen = 0;
      else if (rd_en && !seen) begin
        first_addr = int'(rd_addr);
        seen = 1;
      end
      if (rd_en) rd_total++;
      if (prev_stall) begin
        chk("hold_valid", int'(px_valid), 1);
        chk("hold_data", int'(px_data), int'(prev_data));
        chk("hold_last", int'(px_last), int'(prev_last));
      end
      if (px_valid && px_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got=%0h expected=none", px_data);
        end else begin
          e = sb.pop_front();
          chk($sformatf("beat%0d_data", beat), int'(px_data), int'(e[7:0]));
          chk($sformatf("beat%0d_last", beat), int'(px_last), int'(e[8]));
        end
        if (px_last) begin
          last_cyc = cyc;
          beat = 0;
        end else beat++;
      end
      prev_stall = px_valid && !px_ready;
      prev_data  = px_data;
      prev_last  = px_last;
    end
  end

  // monitor for the INVERT instance (always ready)
  initial forever begin
    @(negedge clk24);
    if (!rst && px_valid2) begin
      chk($sformatf("inv_beat%0d_data", beat2), int'(px_data2), is_pad(beat2) ? 8'h7F : 8'hEF);
      chk($sformatf("inv_beat%0d_last", beat2), int'(px_last2), int'(beat2 == 1023));
      beat2++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, rd0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

    // reset state
    repeat (3) @(posedge clk24);
    #1 rst = 1'b0;
    rdy_mode = 1;
    @(negedge clk24);
    chk("rst_px_valid", int'(px_valid), 0);
    chk("rst_px_data", int'(px_data), 0);
    chk("rst_px_last", int'(px_last), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    chk("rst_doing", int'(lenet_doing_signal), 1);

    // 1: full frame, px_ready held high, plus INVERT instance in parallel
    push_frame();
    rd0 = rd_total;
    @(posedge clk24); #1 lenet_data_ready = 1'b1; pulse2 = 1'b1; n0 = cyc;
    @(posedge clk24); #1 lenet_data_ready = 1'b0; pulse2 = 1'b0;
    @(negedge clk24);
    chk("t1_valid_n1", int'(px_valid), 0);
    chk("t1_doing_n1", int'(lenet_doing_signal), 0);
    chk("t1_busy_n1", int'(busy), 1);
    @(negedge clk24);
    chk("t1_valid_n2", int'(px_valid), 1);
    wait_done("t1_done_timeout");
    chk("t1_doing_after", int'(lenet_doing_signal), 1);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_rd_en_count", rd_total - rd0, 784);
    chk("t1_first_addr", first_addr, 66);
    chk("t1_last_cycle", last_cyc, n0 + 1025);
    chk("t6_beat_count", beat2, 1024);
    chk("t6_doing_after", int'(doing2), 1);

    // 2: random back-pressure
    rdy_mode = 2;
    push_frame();
    rd0 = rd_total;
    pulse1();
    wait_done("t2_done_timeout");
    chk("t2_rd_en_count", rd_total - rd0, 784);
    chk("t2_drop_cnt", int'(drop_cnt), 0);

    // 3: second pulse mid-stream is dropped
    rdy_mode = 1;
    push_frame();
    pulse1();
    wait_beat(300);
    pulse1();
    wait_done("t3_done_timeout");
    chk("t3_drop_cnt", int'(drop_cnt), 1);
    chk("t3_doing_after", int'(lenet_doing_signal), 1);

    // 4: 300 more ignored pulses during a stall, counter saturates
    rdy_mode = 0;
    push_frame();
    @(posedge clk24); #1 lenet_data_ready = 1'b1;
    repeat (301) @(posedge clk24);
    #1 lenet_data_ready = 1'b0;
    rdy_mode = 1;
    wait_done("t4_done_timeout");
    chk("t4_drop_sat", int'(drop_cnt), 255);

    // 5: reset at beat 500 (with a coincident pulse), then restart
    push_frame();
    pulse1();
    wait_beat(500);
    @(posedge clk24); #1 rst = 1'b1; lenet_data_ready = 1'b1;
    @(posedge clk24); #1 rst = 1'b0; lenet_data_ready = 1'b0;
    sb.delete();
    @(negedge clk24);
    chk("t5_valid", int'(px_valid), 0);
    chk("t5_doing", int'(lenet_doing_signal), 1);
    chk("t5_busy", int'(busy), 0);
    chk("t5_drop_cnt", int'(drop_cnt), 0);
    push_frame();
    @(posedge clk24); #1 lenet_data_ready = 1'b1; n0 = cyc;
    @(posedge clk24); #1 lenet_data_ready = 1'b0;
    wait_done("t5_done_timeout");
    chk("t5_first_addr", first_addr, 66);
    chk("t5_last_cycle", last_cyc, n0 + 1025);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
